// File: rtl/mips_dmem_responder_if.sv
// Load/store request/response bus between the MIPS datapath and its data memory.
interface mips_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/mips_dmem_responder.sv
// Word-organised little-endian data memory with byte/half/word access, error
// checking and a programmable wait-state delay before each response.
module mips_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_dmem_responder_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              r_write;
    logic [1:0]        r_size;
    logic [31:0]       r_addr, r_wdata;
    logic              r_ready, r_busy, r_resp_valid, r_resp_err, r_pend_err;
    logic [31:0]       r_resp_rdata, r_pend_rdata;
    logic [31:0]       r_mem [DEPTH_WORDS];

    logic              w_accept, w_enter_resp, w_commit, w_err;
    logic              w_write;
    logic [1:0]        w_size;
    logic [31:0]       w_addr, w_wdata, w_word, w_lane_data, w_load_data;
    logic [IDX_W-1:0]  w_idx;
    logic [3:0]        w_lane_mask;

    // In IDLE the live request is used so a zero-wait or error access can finish straight away.
    always_comb begin
        w_write = r_write;
        w_size  = r_size;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        if (r_state == S_IDLE) begin
            w_write = bus.req_write;
            w_size  = bus.req_size;
            w_addr  = bus.req_addr;
            w_wdata = bus.req_wdata;
        end
    end

    always_comb begin
        w_err = 1'b0;
        case (w_size)
            2'b00:   w_err = 1'b0;
            2'b01:   w_err = w_addr[0];
            2'b10:   w_err = |w_addr[1:0];
            default: w_err = 1'b1;
        endcase
        if (w_addr[31:2] >= 30'(DEPTH_WORDS)) w_err = 1'b1;
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && r_ready) begin
                    w_accept   = 1'b1;
                    w_cnt_next = CNT_W'(WAIT_STATES);
                    w_next     = (w_err || (WAIT_STATES == 0)) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
        w_commit     = w_enter_resp && w_write && !w_err;
    end

    // Lane selection and right-justified load extraction.
    always_comb begin
        w_idx  = w_addr[IDX_W+1:2];
        w_word = r_mem[w_idx];
        case (w_size)
            2'b00: begin
                w_lane_mask = 4'b0001 << w_addr[1:0];
                w_lane_data = {4{w_wdata[7:0]}};
                w_load_data = {24'b0, w_word[{w_addr[1:0], 3'b000} +: 8]};
            end
            2'b01: begin
                w_lane_mask = w_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{w_wdata[15:0]}};
                w_load_data = {16'b0, w_word[{w_addr[1], 4'b0000} +: 16]};
            end
            default: begin
                w_lane_mask = 4'b1111;
                w_lane_data = w_wdata;
                w_load_data = w_word;
            end
        endcase
        if (w_err || w_write) w_load_data = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_write <= bus.req_write;
            r_size  <= bus.req_size;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end
    end

    // Result is captured on entry to RESP and presented on the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_pend_rdata <= '0;
            r_pend_err   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_ready      <= (w_next == S_IDLE);
            r_busy       <= (w_next != S_IDLE);
            r_resp_valid <= (r_state == S_RESP);
            if (w_enter_resp) begin
                r_pend_rdata <= w_load_data;
                r_pend_err   <= w_err;
            end
            if (r_state == S_RESP) begin
                r_resp_rdata <= r_pend_rdata;
                r_resp_err   <= r_pend_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
        end else if (w_commit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_lane_mask[b]) r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
            end
        end
    end

    assign bus.req_ready  = r_ready;
    assign bus.busy       = r_busy;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
endmodule
